// File: rtl/fp_add_sub_param.sv
// Multi-cycle parametrised FP adder/subtractor (round-to-nearest-even, denormals flushed).
// IDLE -> ALIGN -> ADD -> NORM -> ROUND -> DONE, with a fixed latency of 4 edges from start to done.
module fp_add_sub_param #(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    localparam int W     = EXP_W + MAN_W + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         op,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] a2,
    output logic [W-1:0] result,
    output logic         done,
    output logic         busy
);

    localparam int MW = MAN_W + 4;   // hidden + fraction + guard/round/sticky
    localparam int EW = EXP_W + 2;   // exponent with headroom for carry and underflow
    localparam logic [EXP_W-1:0] EMAX = '1;

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;
    state_t state, state_nx;

    logic [W-1:0]     x1, x2;
    logic             xop;
    logic             r_sign, r_sub, r_nan, r_inf, r_inf_sign, r_zsign, r_zero;
    logic [EXP_W-1:0] r_exp;
    logic [MW-1:0]    r_ma, r_mb, r_m;
    logic [MW:0]      r_sum;
    logic [EW-1:0]    r_e;

    always_comb begin
        state_nx = state;
        done     = 1'b0;
        busy     = 1'b0;
        case (state)
            IDLE:  if (start) state_nx = ALIGN;
            ALIGN: begin state_nx = ADD;   busy = 1'b1; end
            ADD:   begin state_nx = NORM;  busy = 1'b1; end
            NORM:  begin state_nx = ROUND; busy = 1'b1; end
            ROUND: begin state_nx = DONE;  busy = 1'b1; end
            DONE:  begin
                done = 1'b1;
                if (start) state_nx = ALIGN;
            end
            default: state_nx = IDLE;
        endcase
    end

    // ---------------- align: unpack, classify, order by magnitude, shift B
    logic [EXP_W-1:0] e1, e2, ea, eb, dexp;
    logic [MAN_W-1:0] f1, f2;
    logic [W-2:0]     k1, k2;
    logic [MAN_W:0]   m1, m2;
    logic             s1, s2, z1, z2, i1, i2, n1, n2, swap;
    logic [MW-1:0]    mb_ext, mb_al;
    logic [2*MW-1:0]  mb_sh;

    always_comb begin
        e1 = x1[W-2:MAN_W];
        e2 = x2[W-2:MAN_W];
        f1 = x1[MAN_W-1:0];
        f2 = x2[MAN_W-1:0];
        s1 = x1[W-1];
        s2 = x2[W-1] ^ xop;
        z1 = (e1 == '0);
        z2 = (e2 == '0);
        i1 = (e1 == EMAX) && (f1 == '0);
        i2 = (e2 == EMAX) && (f2 == '0);
        n1 = (e1 == EMAX) && (f1 != '0);
        n2 = (e2 == EMAX) && (f2 != '0);
        m1 = z1 ? '0 : {1'b1, f1};
        m2 = z2 ? '0 : {1'b1, f2};
        k1 = z1 ? '0 : x1[W-2:0];
        k2 = z2 ? '0 : x2[W-2:0];
        swap   = (k2 > k1);
        ea     = swap ? e2 : e1;
        eb     = swap ? e1 : e2;
        dexp   = ea - eb;
        mb_ext = {(swap ? m1 : m2), 3'b000};
        // the low half of the wide shift catches every bit that falls off into sticky
        mb_sh  = {mb_ext, {MW{1'b0}}} >> dexp;
        if (32'(dexp) >= MAN_W + 3)
            mb_al = {{(MW-1){1'b0}}, |mb_ext};
        else
            mb_al = mb_sh[2*MW-1:MW] | {{(MW-1){1'b0}}, |mb_sh[MW-1:0]};
    end

    // ---------------- normalise: carry shift right, otherwise leading-zero shift left
    int            lz;
    logic [MW-1:0] nm;
    logic [EW-1:0] ne;

    always_comb begin
        lz = MW;
        for (int i = 0; i < MW; i++)
            if (r_sum[i]) lz = MW - 1 - i;
        if (r_sum[MW]) begin
            nm = {r_sum[MW:2], r_sum[1] | r_sum[0]};
            ne = {2'b00, r_exp} + EW'(1);
        end else begin
            nm = r_sum[MW-1:0] << lz;
            ne = {2'b00, r_exp} - EW'(lz);
        end
    end

    // ---------------- round to nearest even, then special-value overrides
    logic             up;
    logic [MAN_W+1:0] rm;
    logic [MAN_W-1:0] rf;
    logic [EW-1:0]    re;
    logic [W-1:0]     res_nx;

    always_comb begin
        up = r_m[2] & (r_m[1] | r_m[0] | r_m[3]);
        rm = {1'b0, r_m[MW-1:3]} + (MAN_W+2)'(up);
        if (rm[MAN_W+1]) begin
            rf = rm[MAN_W:1];
            re = r_e + EW'(1);
        end else begin
            rf = rm[MAN_W-1:0];
            re = r_e;
        end
        res_nx = {r_sign, re[EXP_W-1:0], rf};
        if (r_nan)
            res_nx = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};
        else if (r_inf)
            res_nx = {r_inf_sign, EMAX, {MAN_W{1'b0}}};
        else if (r_zero)
            res_nx = {r_zsign, {(W-1){1'b0}}};
        else if (!re[EW-1] && (re[EW-2:0] >= {1'b0, EMAX}))
            res_nx = {r_sign, EMAX, {MAN_W{1'b0}}};
        else if (re[EW-1] || (re == '0))
            res_nx = {r_sign, {(W-1){1'b0}}};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            result <= '0;
        end else begin
            state <= state_nx;
            if (state == ROUND) result <= res_nx;
        end
    end

    always_ff @(posedge clk) begin
        case (state)
            IDLE, DONE: if (start) begin
                x1  <= a1;
                x2  <= a2;
                xop <= op;
            end
            ALIGN: begin
                r_sign     <= swap ? s2 : s1;
                r_sub      <= s1 ^ s2;
                r_exp      <= ea;
                r_ma       <= {(swap ? m2 : m1), 3'b000};
                r_mb       <= mb_al;
                r_nan      <= n1 | n2 | (i1 & i2 & (s1 ^ s2));
                r_inf      <= i1 | i2;
                r_inf_sign <= i1 ? s1 : s2;
                r_zsign    <= s1 & s2;   // only -0 + -0 keeps a negative zero
            end
            ADD:   r_sum <= r_sub ? ({1'b0, r_ma} - {1'b0, r_mb}) : ({1'b0, r_ma} + {1'b0, r_mb});
            NORM: begin
                r_m    <= nm;
                r_e    <= ne;
                r_zero <= (r_sum == '0);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fp_add_sub_param.sv
// Bench for fp_add_sub_param: directed vectors, handshake/reset scenarios and random ops
// checked against a real-arithmetic reference with explicit round-to-nearest-even.
module tb_fp_add_sub_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, op, done, busy;
    logic [31:0] a1, a2, result;
    logic        starth, oph, doneh, busyh;
    logic [15:0] h1, h2, resh;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    fp_add_sub_param dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a1(a1), .a2(a2),
        .result(result), .done(done), .busy(busy)
    );

    fp_add_sub_param #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .reset(reset), .start(starth), .op(oph), .a1(h1), .a2(h2),
        .result(resh), .done(doneh), .busy(busyh)
    );

    function automatic real mkreal(input bit s, input int ue, input longint f, input int mw);
        logic [63:0] b;
        b = {s, 11'(ue + 1023), 52'(f << (52 - mw))};
        return $bitstoreal(b);
    endfunction

    // Exact sum in double precision, then rounded once to the target format.
    function automatic logic [31:0] ref_fp(input logic [31:0] x, input logic [31:0] y, input bit o,
                                           input int ew, input int mw);
        longint emax, bias, fmask, e1, e2, f1, f2, q, rem, half, eb;
        int sh;
        bit s1, s2, rs;
        real r, v1, v2;
        logic [63:0] rb;
        emax  = (64'(1) << ew) - 1;
        bias  = (64'(1) << (ew - 1)) - 1;
        fmask = (64'(1) << mw) - 1;
        e1 = (longint'(x) >> mw) & emax;
        e2 = (longint'(y) >> mw) & emax;
        f1 = longint'(x) & fmask;
        f2 = longint'(y) & fmask;
        s1 = x[ew+mw];
        s2 = y[ew+mw] ^ o;
        if ((e1 == emax && f1 != 0) || (e2 == emax && f2 != 0) || (e1 == emax && e2 == emax && s1 != s2))
            return 32'((emax << mw) | (64'(1) << (mw - 1)));
        if (e1 == emax) return 32'((longint'(s1) << (ew + mw)) | (emax << mw));
        if (e2 == emax) return 32'((longint'(s2) << (ew + mw)) | (emax << mw));
        v1 = (e1 == 0) ? 0.0 : mkreal(s1, int'(e1 - bias), f1, mw);
        v2 = (e2 == 0) ? 0.0 : mkreal(s2, int'(e2 - bias), f2, mw);
        r  = v1 + v2;
        if (r == 0.0)
            return (e1 == 0 && e2 == 0 && s1 && s2) ? 32'(64'(1) << (ew + mw)) : 32'h0;
        rb   = $realtobits(r);
        rs   = rb[63];
        eb   = longint'(rb[62:52]) - 1023 + bias;
        q    = longint'({1'b1, rb[51:0]});
        sh   = 52 - mw;
        rem  = q & ((64'(1) << sh) - 1);
        half = 64'(1) << (sh - 1);
        q    = q >> sh;
        if (rem > half || (rem == half && (q % 2) == 1)) q++;
        if (q == (64'(1) << (mw + 1))) begin
            q = q >> 1;
            eb++;
        end
        if (eb >= emax) return 32'((longint'(rs) << (ew + mw)) | (emax << mw));
        if (eb <= 0)    return 32'(longint'(rs) << (ew + mw));
        return 32'((longint'(rs) << (ew + mw)) | (eb << mw) | (q & fmask));
    endfunction

    function automatic logic [31:0] rnd_fp(input int ew, input int mw, input int ebase);
        int emax, e, k;
        longint f;
        emax = (1 << ew) - 1;
        k    = int'($urandom_range(0, 19));
        f    = longint'($urandom) & ((64'(1) << mw) - 1);
        if (k == 0) e = 0;
        else if (k == 1) begin e = emax; f = 0; end
        else if (k == 2) begin e = emax; f = f | 1; end
        else if (k == 3) e = emax - 1;
        else begin
            e = ebase + int'($urandom_range(0, 2 * (mw + 5))) - (mw + 5);
            if (e < 1) e = 1;
            if (e > emax - 1) e = emax - 1;
        end
        return 32'((longint'($urandom_range(0, 1)) << (ew + mw)) | (longint'(e) << mw) | f);
    endfunction

    task automatic drive32(input logic [31:0] x, input logic [31:0] y, input logic o,
                           output logic [31:0] res, output int lat, output logic [1:0] db);
        @(negedge clk);
        a1 = x; a2 = y; op = o; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        db = {done, busy};
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done) begin lat = i; break; end
        end
        res = result;
    endtask

    task automatic drive16(input logic [15:0] x, input logic [15:0] y, input logic o,
                           output logic [15:0] res, output int lat);
        @(negedge clk);
        h1 = x; h2 = y; oph = o; starth = 1'b1;
        @(posedge clk); #1;
        starth = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (doneh) begin lat = i; break; end
        end
        res = resh;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({result, done, busy} !== 34'h0) begin
            n_bad++;
            $display("FAIL reset32 got res=%h done=%b busy=%b want 0/0/0", result, done, busy);
        end
        n_cmp++;
        if ({resh, doneh, busyh} !== 18'h0) begin
            n_bad++;
            $display("FAIL reset16 got res=%h done=%b busy=%b want 0/0/0", resh, doneh, busyh);
        end
        @(negedge clk) reset = 1'b0;
    endtask

    task automatic test_directed;
        logic [31:0] ta[14], tb[14], tr[14];
        logic        to[14];
        logic [31:0] res;
        logic [1:0]  db;
        int          lat;
        ta = '{32'h3FE00000, 32'h40500000, 32'h40500000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h7F800000,
               32'h7F7FFFFF, 32'h00400000, 32'h80000000, 32'h80000000, 32'h00000000, 32'hFF800000, 32'h7FC12345};
        tb = '{32'h40500000, 32'h3FE00000, 32'hBFE00000, 32'h3F800000, 32'h33800000, 32'h34400000, 32'h7F800000,
               32'h7F7FFFFF, 32'h3F800000, 32'h80000000, 32'h00000000, 32'h80000000, 32'h3F800000, 32'h3F800000};
        to = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tr = '{32'h40A00000, 32'h3FC00000, 32'h3FC00000, 32'h00000000, 32'h3F800000, 32'h3F800002, 32'h7FC00000,
               32'h7F800000, 32'h3F800000, 32'h80000000, 32'h80000000, 32'h00000000, 32'hFF800000, 32'h7FC00000};
        for (int i = 0; i < 14; i++) begin
            drive32(ta[i], tb[i], to[i], res, lat, db);
            n_cmp++;
            if (res !== tr[i]) begin
                n_bad++;
                $display("FAIL dir%0d result got %h want %h", i, res, tr[i]);
            end
            n_cmp++;
            if (lat != 4 || busy !== 1'b0 || db !== 2'b01) begin
                n_bad++;
                $display("FAIL dir%0d timing got lat=%0d busy@done=%b db=%b want 4/0/01", i, lat, busy, db);
            end
        end
    endtask

    task automatic test_half;
        logic [15:0] ha[3], hb[3], hr[3];
        logic        ho[3];
        logic [15:0] res;
        int          lat;
        ha = '{16'h3C00, 16'h7BFF, 16'h3C00};
        hb = '{16'h3C00, 16'h7BFF, 16'h3C00};
        ho = '{1'b0, 1'b0, 1'b1};
        hr = '{16'h4000, 16'h7C00, 16'h0000};
        for (int i = 0; i < 3; i++) begin
            drive16(ha[i], hb[i], ho[i], res, lat);
            n_cmp++;
            if (res !== hr[i] || lat != 4) begin
                n_bad++;
                $display("FAIL half%0d got %h lat %0d want %h lat 4", i, res, lat, hr[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] res;
        logic [1:0]  db;
        int          lat;
        drive32(32'h3FE00000, 32'h40500000, 1'b0, res, lat, db);
        drive32(32'h40500000, 32'h3FE00000, 1'b1, res, lat, db);
        n_cmp++;
        if (db !== 2'b01) begin
            n_bad++;
            $display("FAIL b2b_accept got done/busy=%b want 01", db);
        end
        n_cmp++;
        if (res !== 32'h3FC00000 || lat != 4) begin
            n_bad++;
            $display("FAIL b2b_result got %h lat %0d want 3fc00000 lat 4", res, lat);
        end
    endtask

    task automatic test_busy_ignore;
        int c;
        @(negedge clk);
        a1 = 32'h3FE00000; a2 = 32'h40500000; op = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        a1 = 32'h3F800000; a2 = 32'h3F800000; op = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b0;
        c = 2;
        while (!done && c < 20) begin
            @(posedge clk); #1;
            c++;
        end
        n_cmp++;
        if (c != 4 || result !== 32'h40A00000) begin
            n_bad++;
            $display("FAIL busy_ignore got %h at %0d want 40a00000 at 4", result, c);
        end
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if (!done || busy || result !== 32'h40A00000) begin
            n_bad++;
            $display("FAIL busy_noqueue got done=%b busy=%b res=%h want 1/0/40a00000", done, busy, result);
        end
    endtask

    task automatic test_reset_abort;
        logic [31:0] res;
        logic [1:0]  db;
        int          lat, pulses;
        @(negedge clk);
        a1 = 32'h3F800000; a2 = 32'h40500000; op = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({result, done, busy} !== 34'h0) begin
            n_bad++;
            $display("FAIL abort_reset got res=%h done=%b busy=%b want 0/0/0", result, done, busy);
        end
        reset = 1'b0;
        pulses = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        n_cmp++;
        if (pulses != 0) begin
            n_bad++;
            $display("FAIL abort_nodone got %0d done cycles want 0", pulses);
        end
        drive32(32'h40500000, 32'hBFE00000, 1'b0, res, lat, db);
        n_cmp++;
        if (res !== 32'h3FC00000 || lat != 4) begin
            n_bad++;
            $display("FAIL abort_restart got %h lat %0d want 3fc00000 lat 4", res, lat);
        end
    endtask

    task automatic test_random32;
        logic [31:0] x, y, res, exp;
        logic [1:0]  db;
        logic        o;
        int          lat, eb;
        for (int n = 0; n < 300; n++) begin
            eb = int'($urandom_range(1, 254));
            x  = rnd_fp(8, 23, eb);
            y  = ($urandom_range(0, 7) == 0) ? x : rnd_fp(8, 23, eb);
            o  = 1'($urandom_range(0, 1));
            exp = ref_fp(x, y, o, 8, 23);
            drive32(x, y, o, res, lat, db);
            n_cmp++;
            if (res !== exp || lat != 4) begin
                n_bad++;
                $display("FAIL rnd32 %h op%0d %h got %h lat %0d want %h lat 4", x, o, y, res, lat, exp);
            end
        end
    endtask

    task automatic test_random16;
        logic [31:0] x, y, exp;
        logic [15:0] res;
        logic        o;
        int          lat, eb;
        for (int n = 0; n < 200; n++) begin
            eb = int'($urandom_range(1, 30));
            x  = rnd_fp(5, 10, eb);
            y  = ($urandom_range(0, 7) == 0) ? x : rnd_fp(5, 10, eb);
            o  = 1'($urandom_range(0, 1));
            exp = ref_fp(x, y, o, 5, 10);
            drive16(x[15:0], y[15:0], o, res, lat);
            n_cmp++;
            if (res !== exp[15:0] || lat != 4) begin
                n_bad++;
                $display("FAIL rnd16 %h op%0d %h got %h lat %0d want %h lat 4", x[15:0], o, y[15:0], res, lat, exp[15:0]);
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 1'b0; a1 = '0; a2 = '0;
        starth = 1'b0; oph = 1'b0; h1 = '0; h2 = '0;
        test_reset();
        test_directed();
        test_half();
        test_back_to_back();
        test_busy_ignore();
        test_reset_abort();
        test_random32();
        test_random16();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
